oq_rr_scheduler: RTL and testbench

Round-robin read scheduler for the SRAM output queues. It picks the next queue to drain from the per-queue empty flags, software enables and downstream-ready signals, and issues one packet-remove request at a time to the remove/read path. It sits between the queue-status registers (empty-flag evaluation) and the packet remover. It masks any queue whose empty flag is stale because a remove's packet-count update has not yet landed.

---
 rtl/oq_rr_scheduler_if.sv | 24 ++
 rtl/oq_rr_scheduler.sv | 117 +++++++++++
 tb/tb_oq_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oq_rr_scheduler_if.sv
// Remove-request handshake between the output-queue
// scheduler and the packet remover.
interface oq_rr_scheduler_if #(
  parameter int NUM_OQ_WIDTH = 3
);
  logic                    rd_req;
  logic [NUM_OQ_WIDTH-1:0] rd_oq;
  logic                    rd_ack;
  logic                    rd_done;

  modport master (
    output rd_req,
    output rd_oq,
    input  rd_ack,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_oq,
    output rd_ack,
    output rd_done
  );
endinterface

// File: rtl/oq_rr_scheduler.sv
// Round-robin read scheduler for the SRAM output
// queues; one packet-remove request in flight.
module oq_rr_scheduler #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH =
    $clog2(NUM_OUTPUT_QUEUES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0] enable,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  oq_rr_scheduler_if.master            rd,
  input  logic                         empty_upd,
  input  logic [NUM_OQ_WIDTH-1:0]      empty_upd_oq,
  input  logic                         initialize,
  input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq,
  output logic                         busy
);

  typedef enum logic [1:0] {
    ARB,
    REQ,
    READ
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_OQ_WIDTH-1:0]      rd_oq_q;
  logic [NUM_OQ_WIDTH-1:0]      last_grant;
  logic [NUM_OUTPUT_QUEUES-1:0] stale;
  logic [NUM_OUTPUT_QUEUES-1:0] stale_nxt;
  logic [NUM_OUTPUT_QUEUES-1:0] eligible;
  logic [NUM_OQ_WIDTH-1:0]      winner;
  logic [NUM_OQ_WIDTH-1:0]      cand;
  logic                         found;
  logic                         acked;

  // A queue is schedulable only when its empty flag is current.
  assign eligible = ~empty & enable & out_rdy & ~stale;

  assign acked = (state == REQ) && rd.rd_ack;

  // First eligible queue after last_grant, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_OUTPUT_QUEUES; k++) begin
      cand = NUM_OQ_WIDTH'(
        (int'(last_grant) + k) % NUM_OUTPUT_QUEUES);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Next-state logic; acks and dones outside REQ/READ are ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:  if (found) state_nxt = REQ;
      REQ:  if (rd.rd_ack)
              state_nxt = rd.rd_done ? ARB : READ;
      READ: if (rd.rd_done) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    rd.rd_req = (state == REQ);
    rd.rd_oq  = rd_oq_q;
    busy      = (state != ARB);
  end

  // Winner is latched only in ARB so rd_oq holds through the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oq_q    <= '0;
      last_grant <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
    end else if (state == ARB && found) begin
      rd_oq_q    <= winner;
      last_grant <= winner;
    end
  end

  // Stale flags: clears first, then the ack set overrides them.
  always_comb begin
    stale_nxt = stale;
    for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      if (empty_upd &&
          empty_upd_oq == NUM_OQ_WIDTH'(i))
        stale_nxt[i] = 1'b0;
      if (initialize &&
          initialize_oq == NUM_OQ_WIDTH'(i))
        stale_nxt[i] = 1'b0;
      if (acked && rd_oq_q == NUM_OQ_WIDTH'(i))
        stale_nxt[i] = 1'b1;
    end
  end

  // Stale flag register.
  always_ff @(posedge clk) begin
    if (reset) stale <= '0;
    else       stale <= stale_nxt;
  end

endmodule

// File: tb/tb_oq_rr_scheduler.sv
// Directed bench for the output-queue
// round-robin scheduler.
module tb_oq_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] empty;
  logic [7:0] enable;
  logic [7:0] out_rdy;
  logic       empty_upd;
  logic [2:0] empty_upd_oq;
  logic       initialize;
  logic [2:0] initialize_oq;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int cnt[8];

  oq_rr_scheduler_if #(.NUM_OQ_WIDTH(3)) rd_if ();

  oq_rr_scheduler #(
    .NUM_OUTPUT_QUEUES(8),
    .NUM_OQ_WIDTH(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .empty        (empty),
    .enable       (enable),
    .out_rdy      (out_rdy),
    .rd           (rd_if),
    .empty_upd    (empty_upd),
    .empty_upd_oq (empty_upd_oq),
    .initialize   (initialize),
    .initialize_oq(initialize_oq),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; also issue delayed empty-flag updates.
  task automatic tick();
    @(posedge clk);
    #1;
    empty_upd    = 1'b0;
    empty_upd_oq = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cnt[i] > 0) cnt[i]--;
      if (cnt[i] == 0) begin
        empty_upd    = 1'b1;
        empty_upd_oq = 3'(i);
        cnt[i]       = -1;
      end
    end
  endtask

  task automatic drain();
    empty = 8'hFF;
    for (int i = 0; i < 25; i++) tick();
  endtask

  // Wait for a grant, check it, ack at once, done next cycle.
  task automatic serve(input int q, input int dly,
                       output int n);
    n = 0;
    while (rd_if.rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'(q))
      $display("FAIL grant: req=%b oq=%0d want req=1 oq=%0d",
               rd_if.rd_req, rd_if.rd_oq, q);
    else passed++;
    total++;
    if (busy !== 1'b1)
      $display("FAIL busy_req: busy=%b want 1", busy);
    else passed++;
    rd_if.rd_ack = 1'b1;
    tick();
    rd_if.rd_ack  = 1'b0;
    total++;
    if (rd_if.rd_req !== 1'b0 || busy !== 1'b1 ||
        rd_if.rd_oq !== 3'(q))
      $display("FAIL read: req=%b busy=%b oq=%0d want 0 1 %0d",
               rd_if.rd_req, busy, rd_if.rd_oq, q);
    else passed++;
    rd_if.rd_done = 1'b1;
    if (dly >= 0) cnt[q] = dly;
    tick();
    rd_if.rd_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (rd_if.rd_req !== 1'b0 || rd_if.rd_oq !== 3'd0 ||
        busy !== 1'b0 || dut.stale !== 8'h00)
      $display("FAIL reset: req=%b oq=%0d busy=%b stale=%h want 0 0 0 00",
               rd_if.rd_req, rd_if.rd_oq, busy, dut.stale);
    else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (rd_if.rd_req !== 1'b0)
      $display("FAIL idle: req=%b want 0", rd_if.rd_req);
    else passed++;
  endtask

  task automatic test_fairness();
    int n;
    int order[6] = '{0, 3, 5, 0, 3, 5};
    empty = ~8'b0010_1001;
    for (int k = 0; k < 6; k++) begin
      serve(order[k], 2, n);
      total++;
      if (n !== 1)
        $display("FAIL latency%0d: waited=%0d want 1", k, n);
      else passed++;
    end
    drain();
  endtask

  task automatic test_stale();
    int n;
    bit ok;
    empty = ~8'b0000_0100;
    serve(2, 20, n);
    ok = (rd_if.rd_req === 1'b0);
    for (int j = 0; j < 19; j++) begin
      tick();
      if (rd_if.rd_req !== 1'b0) ok = 1'b0;
    end
    tick();
    total++;
    if (!ok || rd_if.rd_req !== 1'b0 || dut.stale[2] !== 1'b0)
      $display("FAIL stale_mask: ok=%b req=%b stale2=%b want 1 0 0",
               ok, rd_if.rd_req, dut.stale[2]);
    else passed++;
    tick();
    total++;
    if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd2)
      $display("FAIL stale_regrant: req=%b oq=%0d want 1 2",
               rd_if.rd_req, rd_if.rd_oq);
    else passed++;
    serve(2, 1, n);
    drain();
  endtask

  task automatic test_gating();
    int n;
    bit ok;
    ok = 1'b1;
    empty     = ~8'b0001_0000;
    enable[4] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (rd_if.rd_req !== 1'b0) ok = 1'b0;
    end
    enable[4]  = 1'b1;
    out_rdy[4] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (rd_if.rd_req !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL gating: grant seen while gated");
    else passed++;
    out_rdy[4] = 1'b1;
    tick();
    total++;
    if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd4)
      $display("FAIL gate_open: req=%b oq=%0d want 1 4",
               rd_if.rd_req, rd_if.rd_oq);
    else passed++;
    serve(4, 1, n);
    drain();
  endtask

  task automatic test_stall();
    int n;
    bit ok;
    n = 0;
    empty = ~8'b0100_0000;
    while (rd_if.rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) out_rdy[6] = 1'b0;
      if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd6 ||
          busy !== 1'b1) ok = 1'b0;
      tick();
    end
    total++;
    if (!ok || rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd6)
      $display("FAIL stall_hold: ok=%b req=%b oq=%0d want 1 1 6",
               ok, rd_if.rd_req, rd_if.rd_oq);
    else passed++;
    rd_if.rd_ack = 1'b1;
    tick();
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b1;
    cnt[6] = 1;
    tick();
    rd_if.rd_done = 1'b0;
    out_rdy = 8'hFF;
    drain();
  endtask

  task automatic test_initialize();
    int n;
    empty = ~8'b0000_0010;
    serve(1, -1, n);
    tick();
    tick();
    total++;
    if (rd_if.rd_req !== 1'b0 || dut.stale[1] !== 1'b1)
      $display("FAIL init_masked: req=%b stale1=%b want 0 1",
               rd_if.rd_req, dut.stale[1]);
    else passed++;
    initialize    = 1'b1;
    initialize_oq = 3'd1;
    tick();
    initialize = 1'b0;
    total++;
    if (dut.stale[1] !== 1'b0)
      $display("FAIL init_clear: stale1=%b want 0", dut.stale[1]);
    else passed++;
    tick();
    total++;
    if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd1)
      $display("FAIL init_regrant: req=%b oq=%0d want 1 1",
               rd_if.rd_req, rd_if.rd_oq);
    else passed++;
    rd_if.rd_ack  = 1'b1;
    initialize    = 1'b1;
    initialize_oq = 3'd1;
    tick();
    rd_if.rd_ack = 1'b0;
    initialize   = 1'b0;
    total++;
    if (dut.stale[1] !== 1'b1)
      $display("FAIL set_wins: stale1=%b want 1", dut.stale[1]);
    else passed++;
    rd_if.rd_done = 1'b1;
    cnt[1] = 1;
    tick();
    rd_if.rd_done = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    empty = ~8'b1000_0000;
    while (rd_if.rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    rd_if.rd_ack = 1'b1;
    tick();
    rd_if.rd_ack = 1'b0;
    total++;
    if (busy !== 1'b1 || rd_if.rd_oq !== 3'd7 ||
        dut.stale[7] !== 1'b1)
      $display("FAIL mid_read: busy=%b oq=%0d stale7=%b want 1 7 1",
               busy, rd_if.rd_oq, dut.stale[7]);
    else passed++;
    empty = ~8'b1000_1000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (rd_if.rd_req !== 1'b0 || busy !== 1'b0 ||
        dut.stale !== 8'h00 || rd_if.rd_oq !== 3'd0)
      $display("FAIL mid_reset: req=%b busy=%b stale=%h oq=%0d want 0 0 00 0",
               rd_if.rd_req, busy, dut.stale, rd_if.rd_oq);
    else passed++;
    tick();
    total++;
    if (rd_if.rd_req !== 1'b1 || rd_if.rd_oq !== 3'd3)
      $display("FAIL post_reset: req=%b oq=%0d want 1 3",
               rd_if.rd_req, rd_if.rd_oq);
    else passed++;
    serve(3, 1, n);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) cnt[i] = -1;
    reset         = 1'b1;
    empty         = 8'hFF;
    enable        = 8'hFF;
    out_rdy       = 8'hFF;
    empty_upd     = 1'b0;
    empty_upd_oq  = 3'd0;
    initialize    = 1'b0;
    initialize_oq = 3'd0;
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    test_reset();
    test_fairness();
    test_stale();
    test_gating();
    test_stall();
    test_initialize();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
